// File: rtl/wci_req_arbiter.sv
// wci_req_arbiter: round-robin arbiter of two requesters onto one WCI master port; define WCI_ARB_TIMEOUT_EN for silent-worker timeout
module wci_req_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        wci_Clk,
  input  logic        wci_Reset,
  input  logic        req0_Req,
  input  logic [2:0]  req0_Cmd,
  input  logic        req0_AddrSpace,
  input  logic [3:0]  req0_ByteEn,
  input  logic [19:0] req0_Addr,
  input  logic [31:0] req0_Data,
  output logic        req0_Ack,
  output logic [1:0]  req0_Resp,
  output logic [31:0] req0_RData,
  input  logic        req1_Req,
  input  logic [2:0]  req1_Cmd,
  input  logic        req1_AddrSpace,
  input  logic [3:0]  req1_ByteEn,
  input  logic [19:0] req1_Addr,
  input  logic [31:0] req1_Data,
  output logic        req1_Ack,
  output logic [1:0]  req1_Resp,
  output logic [31:0] req1_RData,
  output logic [2:0]  wci_MCmd,
  output logic        wci_MAddrSpace,
  output logic [3:0]  wci_MByteEn,
  output logic [19:0] wci_MAddr,
  output logic [31:0] wci_MData,
  input  logic [1:0]  wci_SResp,
  input  logic [31:0] wci_SData,
  input  logic        wci_SThreadBusy,
  output logic [15:0] timeout_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic ptr, port, pick, grant, legal, done, tmo, cur_port;
  logic [2:0] pick_cmd, cmd_r;
  logic [1:0] resp_nx;
  logic [31:0] rdata_nx;
  assign pick     = (req0_Req && req1_Req) ? ptr : req1_Req;
  assign pick_cmd = pick ? req1_Cmd : req0_Cmd;
  assign legal    = pick_cmd == 3'h1 || pick_cmd == 3'h2;
  assign grant    = state == IDLE && (req0_Req || req1_Req) && !wci_SThreadBusy;
  assign done     = state == WAIT && wci_SResp != 2'h0;
  assign cur_port = state == IDLE ? pick : port;
  assign resp_nx  = state == IDLE ? 2'h2 : done ? wci_SResp : 2'h3;
  assign rdata_nx = (done && cmd_r == 3'h2) ? wci_SData : 32'h0;
  // state register
  always_ff @(posedge wci_Clk) begin
    if (wci_Reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state: illegal commands skip the bus cycle and complete at once
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? (legal ? ISSUE : RESP) : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (done || tmo) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // request capture, master outputs, completion registers and round-robin pointer
  always_ff @(posedge wci_Clk) begin
    if (wci_Reset) begin
      ptr            <= 1'b0;
      port           <= 1'b0;
      cmd_r          <= 3'h0;
      wci_MCmd       <= 3'h0;
      wci_MAddrSpace <= 1'b0;
      wci_MByteEn    <= 4'h0;
      wci_MAddr      <= 20'h0;
      wci_MData      <= 32'h0;
      req0_Ack       <= 1'b0;
      req1_Ack       <= 1'b0;
      req0_Resp      <= 2'h0;
      req1_Resp      <= 2'h0;
      req0_RData     <= 32'h0;
      req1_RData     <= 32'h0;
    end else begin
      wci_MCmd <= state_nx == ISSUE ? pick_cmd : 3'h0;
      req0_Ack <= state_nx == RESP && !cur_port;
      req1_Ack <= state_nx == RESP && cur_port;
      if (grant) begin
        port           <= pick;
        cmd_r          <= pick_cmd;
        wci_MAddrSpace <= pick ? req1_AddrSpace : req0_AddrSpace;
        wci_MByteEn    <= pick ? req1_ByteEn : req0_ByteEn;
        wci_MAddr      <= pick ? req1_Addr : req0_Addr;
        wci_MData      <= pick ? req1_Data : req0_Data;
      end
      if (state_nx == RESP && !cur_port) begin
        req0_Resp  <= resp_nx;
        req0_RData <= rdata_nx;
      end
      if (state_nx == RESP && cur_port) begin
        req1_Resp  <= resp_nx;
        req1_RData <= rdata_nx;
      end
      if (state == RESP) ptr <= ~port;
    end
  end
`ifdef WCI_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = state == WAIT && wci_SResp == 2'h0 && cnt == TIMEOUT_CYCLES - 8'd1;
  // silent-cycle counter per transaction and saturating timeout tally
  always_ff @(posedge wci_Clk) begin
    if (wci_Reset) begin
      cnt           <= 8'h0;
      timeout_count <= 16'h0;
    end else begin
      cnt <= state == WAIT ? cnt + 8'd1 : 8'h0;
      if (tmo && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign timeout_count  = 16'h0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
endmodule

// File: tb/tb_wci_req_arbiter.sv
// tb_wci_req_arbiter: randomized transaction-level check of the two-port WCI arbiter
module tb_wci_req_arbiter;
  localparam int TMO = 8;
`ifdef WCI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic req[2];
  logic [2:0] cmd[2];
  logic aspace[2];
  logic [3:0] be[2];
  logic [19:0] addr[2];
  logic [31:0] data[2];
  logic ack[2];
  logic [1:0] resp[2];
  logic [31:0] rdata[2];
  logic [2:0] mcmd;
  logic maspace;
  logic [3:0] mbe;
  logic [19:0] maddr;
  logic [31:0] mdata;
  logic [1:0] sresp;
  logic [31:0] sdata;
  logic busy;
  logic [15:0] tcount;
  int checks = 0, errors = 0;
  int ptr = 0, exp_tmo = 0;
  logic [1:0] last_resp[2];
  logic [31:0] last_rdata[2];
  always #5 clk = ~clk;
  wci_req_arbiter #(.TIMEOUT_CYCLES(8'(TMO))) dut (
    .wci_Clk(clk), .wci_Reset(rst),
    .req0_Req(req[0]), .req0_Cmd(cmd[0]), .req0_AddrSpace(aspace[0]), .req0_ByteEn(be[0]),
    .req0_Addr(addr[0]), .req0_Data(data[0]), .req0_Ack(ack[0]), .req0_Resp(resp[0]), .req0_RData(rdata[0]),
    .req1_Req(req[1]), .req1_Cmd(cmd[1]), .req1_AddrSpace(aspace[1]), .req1_ByteEn(be[1]),
    .req1_Addr(addr[1]), .req1_Data(data[1]), .req1_Ack(ack[1]), .req1_Resp(resp[1]), .req1_RData(rdata[1]),
    .wci_MCmd(mcmd), .wci_MAddrSpace(maspace), .wci_MByteEn(mbe), .wci_MAddr(maddr), .wci_MData(mdata),
    .wci_SResp(sresp), .wci_SData(sdata), .wci_SThreadBusy(busy), .timeout_count(tcount)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic new_req(input int p, input bit legal_only);
    req[p]    = 1'b1;
    cmd[p]    = (!legal_only && $urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(1, 2));
    aspace[p] = 1'($urandom);
    be[p]     = 4'($urandom);
    addr[p]   = 20'($urandom);
    data[p]   = $urandom;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_mcmd"}, mcmd, 0);
    chk({tag, "_mfields"}, {maspace, mbe, maddr}, 0);
    chk({tag, "_mdata"}, mdata, 0);
    chk({tag, "_acks"}, {ack[0], ack[1]}, 0);
    chk({tag, "_resps"}, {resp[0], resp[1]}, 0);
    chk({tag, "_rdata0"}, rdata[0], 0);
    chk({tag, "_rdata1"}, rdata[1], 0);
    chk({tag, "_tmo"}, tcount, 0);
  endtask
  // Entered at a negedge with the DUT idle; the next rising edge is the arbitration edge.
  task automatic run_txn(input int nb, input int d, input bit silent, input logic [1:0] code,
                         input logic [31:0] sd, output int w);
    bit legal;
    int nw;
    logic [1:0] er;
    logic [31:0] ed;
    w = (req[0] && req[1]) ? ptr : (req[1] ? 1 : 0);
    legal = cmd[w] == 3'h1 || cmd[w] == 3'h2;
    sresp = 2'($urandom_range(1, 3));
    busy = nb > 0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      chk("busy_mcmd", mcmd, 0);
      chk("busy_ack", {ack[0], ack[1]}, 0);
    end
    busy = 1'b0;
    @(negedge clk);
    sresp = 2'h0;
    if (legal) begin
      chk("issue_cmd", mcmd, cmd[w]);
      chk("issue_addr", maddr, addr[w]);
      chk("issue_data", mdata, data[w]);
      chk("issue_be_sp", {mbe, maspace}, {be[w], aspace[w]});
      chk("issue_ack", {ack[0], ack[1]}, 0);
      nw = silent ? TMO : d + 1;
      for (int k = 1; k <= nw; k++) begin
        @(negedge clk);
        chk("wait_cmd", mcmd, 0);
        chk("wait_addr", maddr, addr[w]);
        chk("wait_data", mdata, data[w]);
        chk("wait_ack", {ack[0], ack[1]}, 0);
        if (!silent && k == nw) begin
          sresp = code;
          sdata = sd;
        end
      end
      @(negedge clk);
      sresp = 2'h0;
      sdata = $urandom;
      er = silent ? 2'h3 : code;
      ed = (!silent && cmd[w] == 3'h2) ? sd : 32'h0;
      if (silent && exp_tmo < 65535) exp_tmo++;
    end else begin
      chk("illegal_mcmd", mcmd, 0);
      er = 2'h2;
      ed = 32'h0;
    end
    chk("ack_win", ack[w], 1);
    chk("ack_other", ack[1 - w], 0);
    chk("resp_win", resp[w], er);
    chk("rdata_win", rdata[w], ed);
    chk("resp_hold", resp[1 - w], last_resp[1 - w]);
    chk("rdata_hold", rdata[1 - w], last_rdata[1 - w]);
    chk("tmo_count", tcount, exp_tmo);
    last_resp[w] = er;
    last_rdata[w] = ed;
    ptr = 1 - w;
    req[w] = 1'b0;
    @(negedge clk);
    chk("idle_ack", {ack[0], ack[1]}, 0);
    chk("idle_mcmd", mcmd, 0);
  endtask
  initial begin
    int w, nb, d;
    bit sil;
    rst = 1'b1;
    busy = 1'b0;
    sresp = 2'h1;
    sdata = 32'hDEAD_BEEF;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; cmd[p] = 3'h0; aspace[p] = 1'b0; be[p] = 4'h0; addr[p] = 20'h0; data[p] = 32'h0;
      last_resp[p] = 2'h0; last_rdata[p] = 32'h0;
    end
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    sresp = 2'h0;
    new_req(0, 1);
    new_req(1, 1);
    cmd[1] = 3'h1;
    data[1] = 32'hA5A5_A5A5;
    data[0] = 32'h0F0F_0F0F;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 0, 1'b0, 2'h1, $urandom, w);
      chk("alternate", w, i % 2);
      new_req(w, 1);
      if (w == 1) begin cmd[1] = 3'h1; data[1] = 32'hA5A5_A5A5; end
      else if (data[0] == 32'hA5A5_A5A5) data[0] = 32'h1;
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    new_req(0, 1);
    cmd[0] = 3'h2;
    addr[0] = 20'h00004;
    run_txn(0, 0, 1'b0, 2'h1, 32'h1234_5678, w);
    chk("read_resp", resp[0], 1);
    chk("read_rdata", rdata[0], 32'h1234_5678);
    new_req(1, 1);
    run_txn(10, 1, 1'b0, 2'h2, $urandom, w);
    new_req(1, 1);
    cmd[1] = 3'h5;
    run_txn(0, 0, 1'b0, 2'h1, $urandom, w);
    if (TO_EN) begin
      new_req(0, 1);
      run_txn(0, 0, 1'b1, 2'h1, $urandom, w);
      new_req(0, 1);
      run_txn(0, TMO - 1, 1'b0, 2'h1, $urandom, w);
    end
    sresp = 2'h1;
    repeat (5) begin
      @(negedge clk);
      chk("late_sresp_ack", {ack[0], ack[1]}, 0);
      chk("late_sresp_cmd", mcmd, 0);
      chk("late_sresp_tmo", tcount, exp_tmo);
    end
    sresp = 2'h0;
    for (int it = 0; it < 150; it++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 1) == 1) new_req(p, 0);
      if (!req[0] && !req[1]) new_req(int'($urandom_range(0, 1)), 0);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      d = ($urandom_range(0, 5) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
      sil = TO_EN && $urandom_range(0, 7) == 0;
      run_txn(nb, d, sil, 2'($urandom_range(1, 3)), $urandom, w);
    end
    new_req(0, 1);
    new_req(1, 1);
    cmd[0] = 3'h2;
    addr[1] = ~addr[0];
    data[1] = ~data[0];
    if (ptr == 0) begin
      run_txn(0, 0, 1'b0, 2'h1, $urandom, w);
      new_req(0, 1);
      addr[1] = ~addr[0];
      data[1] = ~data[0];
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sresp = 2'h1;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0;
    ptr = 0;
    exp_tmo = 0;
    for (int p = 0; p < 2; p++) begin last_resp[p] = 2'h0; last_rdata[p] = 32'h0; end
    run_txn(0, 1, 1'b0, 2'h1, $urandom, w);
    chk("post_reset_grant", w, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
